traffic_phase_sequencer: RTL
============================

// Module: traffic_phase_sequencer
// PURPOSE
//  Upstream vehicle-signal sequencer for one two-road intersection. Cycles NS/EW through
//  green -> yellow -> all-red and drives per-direction lamps. Feeds the pedestrian stage:
//  ns_red/ew_red gate walk windows; ns_green_delay/ew_green_delay size them.
//  Includes a flashing-yellow fault/maintenance mode.
// PARAMETERS
//  NS_GREEN_CYCLES    500_000_000  default NS green length (clk cycles), used when cfg_ns_green==0
//  EW_GREEN_CYCLES    400_000_000  default EW green length, used when cfg_ew_green==0
//  YELLOW_CYCLES      150_000_000  yellow length, both directions (>=1)
//  ALL_RED_CYCLES     50_000_000   all-red clearance length (>=1)
//  FLASH_HALF_CYCLES  25_000_000   flash-mode yellow half period (>=1)
// PORTS
//  clk             in   1   system clock
//  rst             in   1   asynchronous, active-high reset
//  cfg_ns_green    in   32  NS green override, cycles; 0 = use parameter
//  cfg_ew_green    in   32  EW green override, cycles; 0 = use parameter
//  flash_en        in   1   1 = enter/stay in flashing-yellow mode
//  ns_red          out  1   NS red lamp
//  ns_yellow       out  1   NS yellow lamp
//  ns_green        out  1   NS green lamp
//  ew_red          out  1   EW red lamp
//  ew_yellow       out  1   EW yellow lamp
//  ew_green        out  1   EW green lamp
//  ns_green_delay  out  32  green length latched for the current/last NS green
//  ew_green_delay  out  32  green length latched for the current/last EW green
//  phase           out  3   current state code
//  phase_counter   out  32  cycles elapsed in current state (0-based)
//  phase_done      out  1   1 on the last cycle of a timed state
// BEHAVIOUR
//  - States/codes: ALL_RED_A=0, NS_GREEN=1, NS_YELLOW=2, ALL_RED_B=3, EW_GREEN=4,
//    EW_YELLOW=5, FLASH=6. Code 7 is illegal; recover to ALL_RED_A with counter 0.
//  - Sequence: ALL_RED_A -> NS_GREEN -> NS_YELLOW -> ALL_RED_B -> EW_GREEN -> EW_YELLOW
//    -> ALL_RED_A.
//  - Durations: ALL_RED_* = ALL_RED_CYCLES; *_YELLOW = YELLOW_CYCLES;
//    NS_GREEN = ns_green_delay; EW_GREEN = ew_green_delay.
//  - Counter increments every clk in a timed state.
//  - When phase_counter == duration-1: phase_done=1 (combinational). On the next edge,
//    state advances and counter resets to 0.
//  - Green latch: on the edge entering NS_GREEN, ns_green_delay <= (cfg_ns_green==0) ?
//    NS_GREEN_CYCLES : cfg_ns_green; EW identical. cfg changes during a green have no
//    effect until the next entry. Latched values hold outside green.
//  - Lamps: direct decode of the state register, no extra latency. Exactly one of
//    red/yellow/green is 1 per direction in timed states.
//  - ns_red=1 in ALL_RED_A, ALL_RED_B, EW_GREEN, EW_YELLOW. ew_red=1 in ALL_RED_*,
//    NS_GREEN, NS_YELLOW.
//  - FLASH entry: flash_en=1 sampled on any edge -> FLASH, counter 0, on that edge.
//    This has priority over phase advance.
//  - In FLASH: all red/green lamps = 0. ns_yellow = ew_yellow = blink. blink starts 1 on
//    entry and toggles when counter == FLASH_HALF_CYCLES-1 (counter then wraps to 0).
//    phase_done = 0.
//  - FLASH exit: flash_en=0 sampled in FLASH -> ALL_RED_A, counter 0.
//  - Reset (async, any time incl. mid-phase): state ALL_RED_A, counter 0, ns_red=ew_red=1,
//    all other lamps 0, ns_green_delay=NS_GREEN_CYCLES, ew_green_delay=EW_GREEN_CYCLES,
//    phase_done=0 (ALL_RED_CYCLES>1).
//  - Counter is 32-bit and cannot wrap in practice: durations are <2^32 and the counter
//    resets on every transition.
// TESTING  (NS_GREEN=10, EW_GREEN=8, YELLOW=3, ALL_RED=2, FLASH_HALF=4; edge n = n-th
//           rising edge after rst release)
//  1 Defaults, cfg=0: NS_GREEN@2, NS_YELLOW@12, ALL_RED_B@15, EW_GREEN@17, EW_YELLOW@25,
//    ALL_RED_A@28, NS_GREEN@30. Check lamp one-hot and ns_red/ew_red per state.
//  2 cfg_ns_green=5 before edge 2 -> ns_green_delay=5 from edge 2, NS_YELLOW@7.
//    Change cfg to 20 at edge 4 -> delay stays 5 this cycle, becomes 20 at next NS_GREEN.
//  3 flash_en=1 sampled at edge 6 (NS_GREEN) -> phase=6, ns_yellow=ew_yellow=1,
//    reds/greens 0. Yellows toggle every 4 edges. Drop flash_en -> ALL_RED_A, then
//    NS_GREEN 2 edges later.
//  4 rst pulse mid-EW_GREEN -> outputs immediately at reset values (async, no clock edge).
//    Sequence restarts as in test 1.
//  5 phase_done: exactly one-cycle pulse at counter 9 of NS_GREEN, 2 of yellows,
//    1 of all-reds; never in FLASH.
//  6 Force illegal state 7 -> next edge phase=0, counter=0.

Source files
------------

// File: rtl/traffic_phase_sequencer_if.sv
// Bundle between the traffic phase sequencer and its controller / pedestrian stage.
//   cfg_ns_green, cfg_ew_green : green-length overrides in cycles (0 = use default)
//   flash_en                   : request flashing-yellow mode
//   ns_/ew_ red/yellow/green   : per-direction lamp drives
//   ns_/ew_green_delay         : green length latched at the last green entry
//   phase, phase_counter       : current state code and cycles spent in it
//   phase_done                 : last cycle of a timed state
// The sequencer attaches through the slave modport; the controller uses master.
interface traffic_phase_sequencer_if;
  logic [31:0] cfg_ns_green;
  logic [31:0] cfg_ew_green;
  logic        flash_en;
  logic        ns_red;
  logic        ns_yellow;
  logic        ns_green;
  logic        ew_red;
  logic        ew_yellow;
  logic        ew_green;
  logic [31:0] ns_green_delay;
  logic [31:0] ew_green_delay;
  logic [2:0]  phase;
  logic [31:0] phase_counter;
  logic        phase_done;

  modport master (
    output cfg_ns_green, cfg_ew_green, flash_en,
    input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
    input  ns_green_delay, ew_green_delay, phase, phase_counter, phase_done
  );

  modport slave (
    input  cfg_ns_green, cfg_ew_green, flash_en,
    output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
    output ns_green_delay, ew_green_delay, phase, phase_counter, phase_done
  );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Vehicle-signal sequencer for a two-road intersection. Cycles NS/EW through
// green -> yellow -> all-red, with a flashing-yellow maintenance mode.
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : traffic_phase_sequencer_if.slave (config/flash request in; lamps, latched
//         green lengths, phase code, phase counter and phase_done out)
module traffic_phase_sequencer #(
  parameter int unsigned NS_GREEN_CYCLES   = 500_000_000,
  parameter int unsigned EW_GREEN_CYCLES   = 400_000_000,
  parameter int unsigned YELLOW_CYCLES     = 150_000_000,
  parameter int unsigned ALL_RED_CYCLES    = 50_000_000,
  parameter int unsigned FLASH_HALF_CYCLES = 25_000_000
) (
  input logic                      clk,
  input logic                      rst,
  traffic_phase_sequencer_if.slave bus
);

  localparam logic [2:0] StAllRedA  = 3'd0;
  localparam logic [2:0] StNsGreen  = 3'd1;
  localparam logic [2:0] StNsYellow = 3'd2;
  localparam logic [2:0] StAllRedB  = 3'd3;
  localparam logic [2:0] StEwGreen  = 3'd4;
  localparam logic [2:0] StEwYellow = 3'd5;
  localparam logic [2:0] StFlash    = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] ns_delay_q, ns_delay_d;
  logic [31:0] ew_delay_q, ew_delay_d;
  logic        blink_q, blink_d;
  logic [31:0] duration;
  logic        timed;
  logic        done;

  always_comb begin
    duration = 32'd0;
    case (state_q)
      StAllRedA, StAllRedB:   duration = 32'(ALL_RED_CYCLES);
      StNsYellow, StEwYellow: duration = 32'(YELLOW_CYCLES);
      StNsGreen:              duration = ns_delay_q;
      StEwGreen:              duration = ew_delay_q;
      default:                duration = 32'd0;
    endcase
  end

  assign timed = (state_q <= StEwYellow);
  assign done  = timed && (cnt_q == duration - 32'd1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 32'd1;
    blink_d    = blink_q;
    ns_delay_d = ns_delay_q;
    ew_delay_d = ew_delay_q;
    if (bus.flash_en) begin
      // Flash request wins over any phase advance.
      if (state_q != StFlash) begin
        state_d = StFlash;
        cnt_d   = 32'd0;
        blink_d = 1'b1;
      end else if (cnt_q == 32'(FLASH_HALF_CYCLES - 1)) begin
        cnt_d   = 32'd0;
        blink_d = ~blink_q;
      end
    end else if (!timed) begin
      // Leaving flash, or recovering from the unused code 7.
      state_d = StAllRedA;
      cnt_d   = 32'd0;
    end else if (done) begin
      cnt_d = 32'd0;
      case (state_q)
        StAllRedA: begin
          state_d    = StNsGreen;
          ns_delay_d = (bus.cfg_ns_green == 32'd0) ? 32'(NS_GREEN_CYCLES) : bus.cfg_ns_green;
        end
        StNsGreen:  state_d = StNsYellow;
        StNsYellow: state_d = StAllRedB;
        StAllRedB: begin
          state_d    = StEwGreen;
          ew_delay_d = (bus.cfg_ew_green == 32'd0) ? 32'(EW_GREEN_CYCLES) : bus.cfg_ew_green;
        end
        StEwGreen:  state_d = StEwYellow;
        default:    state_d = StAllRedA;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StAllRedA;
      cnt_q      <= 32'd0;
      blink_q    <= 1'b0;
      ns_delay_q <= 32'(NS_GREEN_CYCLES);
      ew_delay_q <= 32'(EW_GREEN_CYCLES);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      blink_q    <= blink_d;
      ns_delay_q <= ns_delay_d;
      ew_delay_q <= ew_delay_d;
    end
  end

  // Code 7 shows red both ways until it recovers on the next edge.
  assign bus.ns_red    = (state_q == StAllRedA) || (state_q == StAllRedB) ||
                         (state_q == StEwGreen) || (state_q == StEwYellow) || (state_q == 3'd7);
  assign bus.ns_yellow = (state_q == StNsYellow) || ((state_q == StFlash) && blink_q);
  assign bus.ns_green  = (state_q == StNsGreen);
  assign bus.ew_red    = (state_q == StAllRedA) || (state_q == StAllRedB) ||
                         (state_q == StNsGreen) || (state_q == StNsYellow) || (state_q == 3'd7);
  assign bus.ew_yellow = (state_q == StEwYellow) || ((state_q == StFlash) && blink_q);
  assign bus.ew_green  = (state_q == StEwGreen);

  assign bus.ns_green_delay = ns_delay_q;
  assign bus.ew_green_delay = ew_delay_q;
  assign bus.phase          = state_q;
  assign bus.phase_counter  = cnt_q;
  assign bus.phase_done     = done;

endmodule
